// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Moore-style sequencing FSM for the multicycle MIPS-subset datapath. One
// memory port is shared between instruction fetch and data access; the
// controller produces every mux select and write enable for the current
// cycle, runs a request/ready handshake with memory, stops in HALT on an
// unrecognised opcode and counts retired instructions.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-high; returns to RST and clears the count
//   opcode       instruction[31:26] from the instruction register
//   zero         ALU zero flag (branch resolution happens in the datapath
//                through PCWriteCond, so the FSM itself never branches on it)
//   mem_ready    memory completes the current request this cycle
//   mem_req      memory request (FETCH, MEMRD, MEMWR)
//   MemRead      memory read direction
//   MemWrite     memory write direction
//   IorD         memory address select: 0 = PC, 1 = ALU-out register
//   IRWrite      load the instruction register
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load qualified by zero in the datapath
//   PCSource     00 ALU result, 01 ALU-out register, 10 jump target
//   ALUSrcA      0 = PC, 1 = register A
//   ALUSrcB      00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   ALUOp        00 add, 01 subtract, 10 funct-decoded
//   RegDst       register-file destination select (1 = rd)
//   RegWrite     register-file write enable
//   MemtoReg     register-file write data select (1 = memory)
//   retire       one-cycle pulse when an instruction completes
//   instr_count  retired-instruction count, wraps silently
//   halted       high while parked in HALT after an illegal opcode
//
// State   | meaning
// --------+-----------------------------------------------------------
// RST     | post-reset idle, all outputs low
// FETCH   | read instruction at PC, PC <= PC + 4 when memory answers
// DECODE  | compute branch target, dispatch on opcode
// MEMADR  | compute load/store effective address
// MEMRD   | data read at ALU-out address
// MEMWB   | write loaded data to rt, retire
// MEMWR   | data write at ALU-out address, retire when memory answers
// REXEC   | R-type ALU operation
// RWB     | write ALU result to rd, retire
// BEQ     | compare, conditional PC load to branch target, retire
// JMP     | PC <= jump target, retire
// HALT    | illegal opcode seen, only reset leaves

module multicycle_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSource,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted
);

    typedef enum logic [3:0] {
        RST    = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        REXEC  = 4'd7,
        RWB    = 4'd8,
        BEQ    = 4'd9,
        JMP    = 4'd10,
        HALT   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state;
    state_t state_next;

    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RST;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RST:    state_next = FETCH;
            FETCH:  if (mem_ready) state_next = DECODE;
            DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = REXEC;
                    OP_BEQ:       state_next = BEQ;
                    OP_J:         state_next = JMP;
                    default:      state_next = HALT;
                endcase
            end
            MEMADR: state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_next = MEMWB;
            MEMWB:  state_next = FETCH;
            MEMWR:  if (mem_ready) state_next = FETCH;
            REXEC:  state_next = RWB;
            RWB:    state_next = FETCH;
            BEQ:    state_next = FETCH;
            JMP:    state_next = FETCH;
            HALT:   state_next = HALT;
            default: state_next = RST;
        endcase
    end

    // Outputs follow the state only, except the fetch/store completion
    // strobes which wait for the memory to accept the request.
    always_comb begin
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        retire      = 1'b0;
        halted      = 1'b0;
        unique case (state)
            FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = mem_ready;
            end
            REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
            end
            BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
            end
            JMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style sequencing FSM that drives a multicycle version of the single-cycle MIPS-subset datapath. The controller shares one memory port between instruction fetch and data access, and generates every mux select and write enable per cycle. It handles a ready/request handshake to memory, halts on illegal opcodes, and counts retired instructions. It sits between the instruction register opcode field and the datapath control inputs, replacing main_controller for the multicycle build.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces RST state and clears counter
- opcode  in  6  instruction[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request (FETCH, MEMRD, MEMWR)
- MemRead, MemWrite  out  1 each  memory direction
- IorD  out  1  0 = PC address, 1 = ALU-out address
- IRWrite  out  1  load instruction register
- PCWrite, PCWriteCond  out  1 each  unconditional / branch-conditional PC load
- PCSource  out  2  00 ALU result, 01 ALU-out register, 10 jump target
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 subtract, 10 funct-decoded
- RegDst, RegWrite, MemtoReg  out  1 each  register-file write control
- retire  out  1  one-cycle pulse on instruction completion
- instr_count  out  CNT_W  retired-instruction count
- halted  out  1  sticky illegal-opcode flag

## Operation
- States (4-bit encoding): RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BEQ, JMP, HALT.
- RST -> FETCH unconditionally. RST holds all outputs 0.
- FETCH:
  - Outputs: mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1.
  - Stay while mem_ready=0. Go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00, computing the branch target.
  - Dispatch on opcode:
    - 100011 (lw) and 101011 (sw) -> MEMADR
    - 000000 (R-type) -> REXEC
    - 000100 (beq) -> BEQ
    - 000010 (j) -> JMP
    - any other opcode -> HALT
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if opcode=lw, else MEMWR.
- MEMRD: mem_req=1, MemRead=1, IorD=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; retire. Go to FETCH.
- MEMWR: mem_req=1, MemWrite=1, IorD=1. Stay until mem_ready=1, then retire and go to FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0; retire. Go to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; retire. Go to FETCH.
- JMP: PCWrite=1, PCSource=10; retire. Go to FETCH.
- HALT: halted=1, all other outputs 0. Only reset leaves HALT.
- Outputs not listed for a state are 0.
- Counter:
  - instr_count increments by 1 in the cycle retire=1.
  - It wraps from all-ones to 0 with no flag.
  - It holds in HALT.

## Timing
- State and instr_count are registered on the rising clk edge. Outputs decode combinationally from state, plus mem_ready for IRWrite/PCWrite/retire in memory states.
- Reset values: state=RST, instr_count=0, halted=0, all control outputs 0.
- An asynchronous assert mid-instruction (any state) aborts immediately. No memory write is completed after reset rises.
- Latency with mem_ready tied high, counted from entering FETCH to retire:
  - lw 5 cycles
  - sw 4 cycles
  - R-type 4 cycles
  - beq 3 cycles
  - j 3 cycles
  - Each cycle of mem_ready=0 in FETCH/MEMRD/MEMWR adds exactly one cycle.
- Handshake:
  - mem_req, MemRead/MemWrite and IorD remain stable while waiting.
  - mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- retire is high for exactly one cycle per instruction. It is never asserted in RST, FETCH, DECODE or HALT.

## Test plan
- lw, mem_ready=1 constantly, reset released:
  - State trace RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - MemtoReg=1 and RegWrite=1 only in MEMWB.
  - instr_count 0 -> 1.
- FETCH with mem_ready low for 3 cycles:
  - FETCH lasts 4 cycles with mem_req=1 throughout.
  - IRWrite and PCWrite are pulsed only in the 4th cycle.
- beq (000100) then j (000010):
  - Each takes 3 cycles.
  - PCWriteCond=1 with PCSource=01 in BEQ; PCWrite=1 with PCSource=10 in JMP.
  - instr_count reaches 2.
- Opcode 111111:
  - DECODE -> HALT; halted=1 held for 20 cycles.
  - No retire pulse, instr_count unchanged.
  - reset clears halted to 0.
- sw with mem_ready low, reset asserted in MEMWR:
  - All outputs go 0 asynchronously before the next edge.
  - MemWrite is never seen with mem_ready=1.
  - instr_count=0 after release.
- CNT_W=4, 16 R-type instructions: instr_count goes 15 -> 0 on the 16th retire.
